// File: rtl/eei.sv
// Shared CSR address constants and types for the hardware performance monitor bank.
package eei;

    localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;
    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] HPMCOUNTER3   = 12'hC03;

    // Offset of index 31 from index 3 within each HPM address group.
    localparam logic [11:0] HPM_LAST_OFS = 12'd28;

    localparam int unsigned LOCAL_COUNTER_OVERFLOW_INTERRUPT = 13;

    localparam int unsigned HPM_SEL_W = 8;

    typedef struct packed {
        logic                 of;
        logic [HPM_SEL_W-1:0] sel;
    } HpmEvent;

    function automatic logic in_hpm_range(input logic [11:0] addr, input logic [11:0] base);
        return (addr >= base) && (addr <= base + HPM_LAST_OFS);
    endfunction

endpackage

// File: rtl/hpm_counter_bank_counter.sv
// One HPM counter with its event selector and sticky overflow flag.
module hpm_counter
    import eei::*;
#(
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_EVENTS    = 8,
    parameter int unsigned EVT_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cnt_we,
    input  logic [COUNTER_WIDTH-1:0] i_cnt_wdata,
    input  logic                     i_evt_we,
    input  logic                     i_evt_of,
    input  logic [EVT_W-1:0]         i_evt_sel,
    input  logic [NUM_EVENTS-1:0]    i_events,
    input  logic                     i_inhibit,
    output logic [COUNTER_WIDTH-1:0] o_count,
    output HpmEvent                  o_evt
);

    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_of;
    logic [EVT_W-1:0]         r_sel;

    logic w_evt;
    logic w_inc;
    logic w_wrap;

    // Selector values outside 1..NUM_EVENTS match no line and never count.
    always_comb begin
        w_evt = 1'b0;
        for (int k = 0; k < int'(NUM_EVENTS); k++) begin
            if (r_sel == EVT_W'(k + 1)) begin
                w_evt = i_events[k];
            end
        end
    end

    assign w_inc  = w_evt && !i_inhibit;
    assign w_wrap = w_inc && (&r_count) && !i_cnt_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_of    <= 1'b0;
            r_sel   <= '0;
        end else begin
            if (i_cnt_we) begin
                r_count <= i_cnt_wdata;
            end else if (w_inc) begin
                r_count <= r_count + COUNTER_WIDTH'(1);
            end
            // A wrap in the same cycle as a software clear keeps OF set.
            if (w_wrap) begin
                r_of <= 1'b1;
            end else if (i_evt_we) begin
                r_of <= i_evt_of;
            end
            if (i_evt_we) begin
                r_sel <= i_evt_sel;
            end
        end
    end

    assign o_count   = r_count;
    assign o_evt.of  = r_of;
    assign o_evt.sel = HPM_SEL_W'(r_sel);

endmodule

// File: rtl/hpm_counter_bank.sv
// HPM counter bank: CSR decode, read mux, mcountinhibit and overflow interrupt request.
module hpm_counter_bank
    import eei::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_EVENTS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_valid,
    input  logic                  csr_we,
    input  logic [11:0]           csr_addr,
    input  logic [XLEN-1:0]       csr_wdata,
    output logic                  csr_hit,
    output logic [XLEN-1:0]       csr_rdata,
    output logic                  csr_illegal,
    input  logic [NUM_EVENTS-1:0] events,
    output logic                  ovf_irq
);

    localparam int unsigned EVT_W = $clog2(NUM_EVENTS + 1);

    logic [NUM_COUNTERS-1:0]  r_inhibit;

    logic [4:0]               w_idx;
    logic                     w_is_inh;
    logic                     w_is_evt;
    logic                     w_is_mcnt;
    logic                     w_is_ucnt;
    logic                     w_wr;
    logic [COUNTER_WIDTH-1:0] w_count [NUM_COUNTERS];
    HpmEvent                  w_evt   [NUM_COUNTERS];

    assign w_idx     = csr_addr[4:0];
    assign w_is_inh  = (csr_addr == MCOUNTINHIBIT);
    assign w_is_evt  = in_hpm_range(csr_addr, MHPMEVENT3);
    assign w_is_mcnt = in_hpm_range(csr_addr, MHPMCOUNTER3);
    assign w_is_ucnt = in_hpm_range(csr_addr, HPMCOUNTER3);

    assign csr_hit     = w_is_inh || w_is_evt || w_is_mcnt || w_is_ucnt;
    assign w_wr        = csr_valid && csr_we;
    assign csr_illegal = w_wr && w_is_ucnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inhibit <= '0;
        end else if (w_wr && w_is_inh) begin
            r_inhibit <= csr_wdata[3 +: NUM_COUNTERS];
        end
    end

    for (genvar g = 0; g < int'(NUM_COUNTERS); g++) begin : g_cnt
        localparam logic [4:0] IDX = 5'(g + 3);

        hpm_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .NUM_EVENTS    (NUM_EVENTS),
            .EVT_W         (EVT_W)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .i_cnt_we    (w_wr && w_is_mcnt && (w_idx == IDX)),
            .i_cnt_wdata (csr_wdata[COUNTER_WIDTH-1:0]),
            .i_evt_we    (w_wr && w_is_evt && (w_idx == IDX)),
            .i_evt_of    (csr_wdata[XLEN-1]),
            .i_evt_sel   (csr_wdata[EVT_W-1:0]),
            .i_events    (events),
            .i_inhibit   (r_inhibit[g]),
            .o_count     (w_count[g]),
            .o_evt       (w_evt[g])
        );
    end

    // Unimplemented indices fall through every match and read as zero.
    always_comb begin
        csr_rdata = '0;
        if (w_is_inh) begin
            csr_rdata[3 +: NUM_COUNTERS] = r_inhibit;
        end
        for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            if (w_idx == 5'(i + 3)) begin
                if (w_is_mcnt || w_is_ucnt) begin
                    csr_rdata = XLEN'(w_count[i]);
                end else if (w_is_evt) begin
                    csr_rdata[XLEN-1]        = w_evt[i].of;
                    csr_rdata[HPM_SEL_W-1:0] = w_evt[i].sel;
                end
            end
        end
    end

    always_comb begin
        ovf_irq = 1'b0;
        for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            ovf_irq = ovf_irq | w_evt[i].of;
        end
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised bench for hpm_counter_bank against an array-based CSR model.
module tb_hpm_counter_bank;

    localparam int unsigned XLEN = 64;
    localparam int unsigned N    = 4;
    localparam int unsigned NE   = 8;
    localparam int unsigned CW   = 64;
    localparam int unsigned EW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            csr_valid = 1'b0;
    logic            csr_we = 1'b0;
    logic [11:0]     csr_addr = '0;
    logic [XLEN-1:0] csr_wdata = '0;
    logic            csr_hit;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic [NE-1:0]   events = '0;
    logic            ovf_irq;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0]   m_cnt [32];
    logic          m_of  [32];
    logic [EW-1:0] m_sel [32];
    logic [31:0]   m_inh;

    hpm_counter_bank #(
        .XLEN          (XLEN),
        .NUM_COUNTERS  (N),
        .COUNTER_WIDTH (CW),
        .NUM_EVENTS    (NE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_valid   (csr_valid),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_hit     (csr_hit),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .events      (events),
        .ovf_irq     (ovf_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s addr=%h actual=%h expected=%h t=%0t", name, csr_addr, act, exp, $time);
        end
    endtask

    function automatic logic exp_hit(input logic [11:0] a);
        return (a == 12'h320) || (a >= 12'h323 && a <= 12'h33F) ||
               (a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hC03 && a <= 12'hC1F);
    endfunction

    function automatic logic [63:0] exp_rdata(input logic [11:0] a);
        int   idx;
        logic impl;
        idx  = int'(a) % 32;
        impl = (idx >= 3) && (idx < 3 + int'(N));
        if (!exp_hit(a))  return 64'h0;
        if (a == 12'h320) return {32'h0, m_inh};
        if (!impl)        return 64'h0;
        if (a < 12'h400)  return {m_of[idx], 63'h0} | 64'(m_sel[idx]);
        return m_cnt[idx];
    endfunction

    function automatic logic exp_irq();
        logic r = 1'b0;
        for (int i = 3; i < 3 + int'(N); i++) r = r | m_of[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_cnt[i] = '0;
            m_of[i]  = 1'b0;
            m_sel[i] = '0;
        end
        m_inh = '0;
    endtask

    // One clock edge of architectural behaviour, using the inputs held across it.
    task automatic model_edge();
        logic        wr;
        logic        inc;
        logic        cw;
        logic        ew;
        logic [31:0] new_inh;
        int          s;
        wr = csr_valid && csr_we && exp_hit(csr_addr);
        new_inh = m_inh;
        if (wr && csr_addr == 12'h320) new_inh = 32'(csr_wdata) & (((32'd1 << N) - 1) << 3);
        for (int i = 3; i < 3 + int'(N); i++) begin
            s   = int'(m_sel[i]);
            inc = (s >= 1) && (s <= int'(NE)) && events[s-1] && !m_inh[i];
            cw  = wr && (csr_addr == 12'hB00 + 12'(i));
            ew  = wr && (csr_addr == 12'h320 + 12'(i));
            if (inc && !cw && m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) m_of[i] = 1'b1;
            else if (ew) m_of[i] = csr_wdata[63];
            if (ew) m_sel[i] = EW'(csr_wdata);
            if (cw) m_cnt[i] = csr_wdata;
            else if (inc) m_cnt[i] = m_cnt[i] + 64'd1;
        end
        m_inh = new_inh;
    endtask

    task automatic compare();
        check("hit", 64'(csr_hit), 64'(exp_hit(csr_addr)));
        check("rdata", csr_rdata, exp_rdata(csr_addr));
        check("illegal", 64'(csr_illegal),
              64'(csr_valid && csr_we && csr_addr >= 12'hC03 && csr_addr <= 12'hC1F));
        check("irq", 64'(ovf_irq), 64'(exp_irq()));
    endtask

    task automatic drive(input logic v, input logic we, input logic [11:0] a,
                         input logic [63:0] d, input logic [NE-1:0] ev);
        csr_valid = v;
        csr_we    = we;
        csr_addr  = a;
        csr_wdata = d;
        events    = ev;
    endtask

    task automatic step();
        #1 compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic [NE-1:0] ev);
        drive(1'b1, 1'b1, a, d, ev);
        step();
    endtask

    task automatic peek(input string name, input logic [11:0] a, input logic [63:0] exp,
                        input logic [NE-1:0] ev);
        drive(1'b0, 1'b0, a, 64'h0, ev);
        #1 check(name, csr_rdata, exp);
        step();
    endtask

    task automatic idle(input int n, input logic [NE-1:0] ev);
        repeat (n) begin
            drive(1'b0, 1'b0, 12'h000, 64'h0, ev);
            step();
        end
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom % 8)
            0:       return 12'h320 + 12'($urandom % 3);
            1, 2:    return 12'h323 + 12'($urandom % 5);
            3, 4:    return 12'hB03 + 12'($urandom % 5);
            5:       return 12'hC03 + 12'($urandom % 5);
            6:       return ($urandom % 2) ? 12'hB1F : 12'h33F;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        logic [11:0] a;
        logic [63:0] d;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state.
        peek("rst_cnt3", 12'hB03, 64'h0, '0);
        peek("rst_evt3", 12'h323, 64'h0, '0);
        peek("rst_inh", 12'h320, 64'h0, '0);
        #1 check("rst_irq", 64'(ovf_irq), 64'h0);

        // Basic counting on events[0].
        wr(12'h323, 64'h1, '0);
        idle(5, 8'h01);
        peek("count5", 12'hB03, 64'd5, '0);
        peek("sel0_nocount", 12'hB04, 64'h0, '0);

        // Wrap sets OF and the interrupt; software clears it.
        wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        idle(1, 8'h01);
        peek("wrap_cnt", 12'hB03, 64'h0, '0);
        peek("wrap_of", 12'h323, 64'h8000_0000_0000_0001, '0);
        #1 check("wrap_irq", 64'(ovf_irq), 64'h1);
        wr(12'h323, 64'h1, '0);
        #1 check("clr_irq", 64'(ovf_irq), 64'h0);

        // Inhibit applies from the cycle after its write, in both directions.
        wr(12'h320, 64'h8, 8'h01);
        idle(3, 8'h01);
        peek("inhibit_frozen", 12'hB03, 64'd1, 8'h01);
        wr(12'h320, 64'h0, 8'h01);
        idle(2, 8'h01);
        peek("inhibit_resume", 12'hB03, 64'd3, '0);

        // Write beats same-cycle increment.
        wr(12'hB03, 64'd100, 8'h01);
        peek("write_wins", 12'hB03, 64'd100, '0);

        // User-mode shadow writes and unimplemented indices.
        drive(1'b1, 1'b1, 12'hC03, 64'd55, '0);
        #1 check("illegal_c03", 64'(csr_illegal), 64'h1);
        step();
        peek("c03_nochange", 12'hB03, 64'd100, '0);
        drive(1'b1, 1'b1, 12'hB1F, 64'd5, '0);
        #1 check("hit_b1f", 64'(csr_hit), 64'h1);
        step();
        peek("b1f_zero", 12'hB1F, 64'h0, '0);

        // Out-of-range selector is readable but never counts.
        wr(12'h324, 64'd15, '0);
        peek("sel_big_read", 12'h324, 64'd15, 8'hFF);
        peek("sel_big_nocount", 12'hB04, 64'h0, '0);

        // Overflow in the same cycle as an mhpmevent write clearing OF.
        wr(12'h325, 64'h1, '0);
        wr(12'hB05, 64'hFFFF_FFFF_FFFF_FFFF, '0);
        wr(12'h325, 64'h2, 8'h01);
        peek("race_of", 12'h325, 64'h8000_0000_0000_0002, '0);
        peek("race_cnt", 12'hB05, 64'h0, '0);
        wr(12'h325, 64'h0, '0);

        // Randomised traffic with occasional asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            a = pick_addr();
            if ($urandom % 4 == 0) d = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom % 4);
            else                   d = {$urandom, $urandom};
            drive(($urandom % 4) != 0, $urandom % 2 == 1, a, d, NE'($urandom));
            if ($urandom % 500 == 0) begin
                #2 rst = 1'b0;
                #1 model_reset();
                compare();
                @(negedge clk);
                rst = 1'b1;
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
